sonar_ping_ctrl: RTL and testbench
==================================

Name: sonar_ping_ctrl

Overview:
- Sequences one ultrasonic ranging cycle over the processor's 8-pin GPIO block (io_pin_set) through that block's single-pin write interface (pin_num, in, val_we, mode_we).
- Clears and configures the trigger pin, emits a TRIG_CYCLES-wide trigger pulse, switches the echo pin to input, then measures the echo high time in clock cycles.
- Reports the result to the processor's memory-mapped status logic with a one-cycle done pulse.

Parameters:
- TRIG_CYCLES, 500, trigger high time in clocks (10 us at 50 MHz).
- TIMEOUT_CYCLES, 1500000, maximum wait for echo rise, and separately maximum echo width.
- HOLDOFF_CYCLES, 3000000, quiet time after a measurement before returning to IDLE.
- CNT_W, 32, width of the counter and of distance_cycles.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request one ping; honoured only in IDLE.
- trig_pin  input  3  GPIO index of trigger; latched on accepted start.
- echo_pin  input  3  GPIO index of echo; latched on accepted start.
- io_out  input  8  out bus of io_pin_set (pin readback).
- io_pin_num  output  3  pin_num to io_pin_set.
- io_in  output  1  data bit to io_pin_set.
- io_val_we  output  1  value write enable.
- io_mode_we  output  1  mode write enable (1 = output, 0 = input).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on entry to HOLDOFF.
- timeout  output  1  valid with done: rise or width limit hit.
- cfg_err  output  1  valid with done: trig_pin == echo_pin.
- distance_cycles  output  CNT_W  echo high time; held until next done.

Behaviour:
Reset:
- reset low, asynchronously: FSM = IDLE; counter, distance_cycles, timeout, cfg_err = 0.
- All outputs 0, including both write enables and io_pin_num.
- Reset mid-operation aborts with no further pin writes. The GPIO registers themselves are not reset.

Start acceptance:
- start in IDLE latches trig_pin and echo_pin and moves to CLR_TRIG.
- start in any other state is ignored.

FSM states. Each write state lasts exactly one cycle and asserts exactly one write enable.
- IDLE: waits for start.
- CLR_TRIG: pin = trig, in = 0, val_we = 1. Guarantees a low trigger before the pin becomes an output. If latched pins are equal, go directly to HOLDOFF with cfg_err = 1, no writes issued.
- MODE_TRIG: pin = trig, in = 1, mode_we = 1.
- MODE_ECHO: pin = echo, in = 0, mode_we = 1.
- TRIG_HI: pin = trig, in = 1, val_we = 1; counter cleared.
- TRIG_WAIT: counter increments; leave when counter == TRIG_CYCLES-1. Trigger high time = TRIG_CYCLES+1 clocks.
- TRIG_LO: pin = trig, in = 0, val_we = 1; counter cleared.
- WAIT_RISE:
  - echo_s = 1 → MEASURE with counter = 0.
  - counter == TIMEOUT_CYCLES-1 → HOLDOFF, timeout = 1, distance_cycles = 0.
- MEASURE: counter increments while echo_s = 1.
  - echo_s = 0 → HOLDOFF, distance_cycles = counter.
  - counter == TIMEOUT_CYCLES-1 with echo still high → HOLDOFF, timeout = 1, distance_cycles = TIMEOUT_CYCLES (saturated).
- HOLDOFF: done asserted only in the first cycle. Counter runs HOLDOFF_CYCLES cycles, then IDLE.

Echo synchronisation:
- echo_s = io_out[echo_pin_latched] passed through a 2-flop synchronizer.
- Measured width equals true high time within ±1 clock.
- The fixed 2-cycle latency applies equally to both edges, so it does not bias the width.

Other rules:
- timeout and cfg_err are cleared on every accepted start.
- done, timeout and cfg_err are never simultaneously set with a valid nonzero distance.
- Counter is CNT_W bits. Parameters must satisfy TIMEOUT_CYCLES, HOLDOFF_CYCLES < 2^CNT_W; the counter never wraps.
- io_pin_set registers capture on the falling clock edge. The one-cycle write states are therefore sufficient, and write enables are driven from FSM state registers so they are glitch-free.

Decomposition:
- Shared package sonar_pkg: FSM state enum (4-bit encoding) plus default values for TRIG_CYCLES, TIMEOUT_CYCLES, HOLDOFF_CYCLES.
- One natural sub-module, sync2: 2-flop synchronizer with async active-low clear, reused for all GPIO inputs.

Test Plan:
All tests use TRIG_CYCLES=4, TIMEOUT_CYCLES=64, HOLDOFF_CYCLES=8 with an io_pin_set instance and a behavioural echo model.
- Normal ping: trig=2, echo=5, echo high 20 clk starting 10 clk after trigger falls → write order val0/mode1 on pin 2, mode0 on pin 5, val1/val0 on pin 2; pin 2 high 5 clk; done pulse; distance_cycles = 20 ±1; timeout = 0.
- No echo: echo held low → done 64 clk after TRIG_LO; timeout = 1; distance_cycles = 0.
- Stuck echo: echo held high → timeout = 1; distance_cycles = 64.
- Config error: trig = echo = 3 → done 2 clk after start; cfg_err = 1; no val_we or mode_we ever asserted.
- Start while busy, plus holdoff: pulse start during MEASURE → ignored, exactly one done. busy stays high 8 clk after done; start in that window is ignored.
- Reset mid-TRIG_WAIT: reset low 1 clk → busy = 0 and all outputs 0 immediately. A new start then first drives trig val = 0 before the mode write.

Source files
------------

// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar ping controller: FSM encoding and default timing.
package sonar_pkg;

   localparam int unsigned TRIG_CYCLES_DEF    = 500;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 1500000;
   localparam int unsigned HOLDOFF_CYCLES_DEF = 3000000;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_CLR_TRIG  = 4'd1,
      S_MODE_TRIG = 4'd2,
      S_MODE_ECHO = 4'd3,
      S_TRIG_HI   = 4'd4,
      S_TRIG_WAIT = 4'd5,
      S_TRIG_LO   = 4'd6,
      S_WAIT_RISE = 4'd7,
      S_MEASURE   = 4'd8,
      S_HOLDOFF   = 4'd9
   } state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer with asynchronous active-low clear.
module sync2 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/sonar_ping_ctrl.sv
// One ultrasonic ranging cycle driven through the single-pin GPIO write port;
// reports echo high time in clocks with a one-cycle done pulse.
module sonar_ping_ctrl
   import sonar_pkg::*;
#(
   parameter int unsigned TRIG_CYCLES    = TRIG_CYCLES_DEF,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int unsigned HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF,
   parameter int unsigned CNT_W          = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       trig_pin,
   input  logic [2:0]       echo_pin,
   input  logic [7:0]       io_out,
   output logic [2:0]       io_pin_num,
   output logic             io_in,
   output logic             io_val_we,
   output logic             io_mode_we,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic             cfg_err,
   output logic [CNT_W-1:0] distance_cycles
);

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_SAT    = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       trig_q;
   logic [2:0]       echo_q;
   logic [2:0]       pin_num_q;
   logic             in_q;
   logic             val_we_q;
   logic             mode_we_q;
   logic             done_q;
   logic             timeout_q;
   logic             cfg_err_q;
   logic [CNT_W-1:0] dist_q;

   logic [7:0]       io_sync;
   logic             echo_s;

   sync2 #(.WIDTH(8)) u_sync (
      .clk_i  (clk),
      .rst_ni (reset),
      .d_i    (io_out),
      .q_o    (io_sync)
   );

   assign echo_s = io_sync[echo_q];

   // Write strobes are set on the transition into each write state, so they
   // line up exactly with that state's single cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         trig_q    <= '0;
         echo_q    <= '0;
         pin_num_q <= '0;
         in_q      <= 1'b0;
         val_we_q  <= 1'b0;
         mode_we_q <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         cfg_err_q <= 1'b0;
         dist_q    <= '0;
      end else begin
         pin_num_q <= '0;
         in_q      <= 1'b0;
         val_we_q  <= 1'b0;
         mode_we_q <= 1'b0;
         done_q    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  trig_q    <= trig_pin;
                  echo_q    <= echo_pin;
                  timeout_q <= 1'b0;
                  cfg_err_q <= 1'b0;
                  state_q   <= S_CLR_TRIG;
                  // A shared pin is a config error; no write is issued for it.
                  if (trig_pin != echo_pin) begin
                     pin_num_q <= trig_pin;
                     val_we_q  <= 1'b1;
                  end
               end
            end
            S_CLR_TRIG: begin
               if (trig_q == echo_q) begin
                  cfg_err_q <= 1'b1;
                  dist_q    <= '0;
                  done_q    <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= S_HOLDOFF;
               end else begin
                  pin_num_q <= trig_q;
                  in_q      <= 1'b1;
                  mode_we_q <= 1'b1;
                  state_q   <= S_MODE_TRIG;
               end
            end
            S_MODE_TRIG: begin
               pin_num_q <= echo_q;
               mode_we_q <= 1'b1;
               state_q   <= S_MODE_ECHO;
            end
            S_MODE_ECHO: begin
               pin_num_q <= trig_q;
               in_q      <= 1'b1;
               val_we_q  <= 1'b1;
               cnt_q     <= '0;
               state_q   <= S_TRIG_HI;
            end
            S_TRIG_HI: begin
               state_q <= S_TRIG_WAIT;
            end
            S_TRIG_WAIT: begin
               if (cnt_q == TRIG_LAST) begin
                  pin_num_q <= trig_q;
                  val_we_q  <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= S_TRIG_LO;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            S_TRIG_LO: begin
               state_q <= S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
               if (echo_s) begin
                  cnt_q   <= '0;
                  state_q <= S_MEASURE;
               end else if (cnt_q == TO_LAST) begin
                  timeout_q <= 1'b1;
                  dist_q    <= '0;
                  done_q    <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= S_HOLDOFF;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            S_MEASURE: begin
               if (!echo_s) begin
                  dist_q  <= cnt_q;
                  done_q  <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= S_HOLDOFF;
               end else if (cnt_q == TO_LAST) begin
                  timeout_q <= 1'b1;
                  dist_q    <= TO_SAT;
                  done_q    <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= S_HOLDOFF;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            S_HOLDOFF: begin
               // Done cycle holds count 0; HOLDOFF_CYCLES quiet cycles follow.
               if (cnt_q == HOLD_LAST) begin
                  cnt_q   <= '0;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign io_pin_num      = pin_num_q;
   assign io_in           = in_q;
   assign io_val_we       = val_we_q;
   assign io_mode_we      = mode_we_q;
   assign busy            = (state_q != S_IDLE);
   assign done            = done_q;
   assign timeout         = timeout_q;
   assign cfg_err         = cfg_err_q;
   assign distance_cycles = dist_q;

endmodule

// File: tb/tb_sonar_ping_ctrl.sv
// Scoreboard bench for sonar_ping_ctrl with a behavioural GPIO block and echo source.
module tb_sonar_ping_ctrl;

   localparam int TRIG = 4;
   localparam int TO   = 64;
   localparam int HOLD = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  trig_pin = '0;
   logic [2:0]  echo_pin = '0;
   logic [7:0]  io_out;
   logic [2:0]  io_pin_num;
   logic        io_in, io_val_we, io_mode_we, busy, done, timeout, cfg_err;
   logic [31:0] distance_cycles;

   int checks = 0;
   int errors = 0;
   int done_count = 0;
   int wr_count = 0;

   sonar_ping_ctrl #(
      .TRIG_CYCLES    (TRIG),
      .TIMEOUT_CYCLES (TO),
      .HOLDOFF_CYCLES (HOLD),
      .CNT_W          (32)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .trig_pin        (trig_pin),
      .echo_pin        (echo_pin),
      .io_out          (io_out),
      .io_pin_num      (io_pin_num),
      .io_in           (io_in),
      .io_val_we       (io_val_we),
      .io_mode_we      (io_mode_we),
      .busy            (busy),
      .done            (done),
      .timeout         (timeout),
      .cfg_err         (cfg_err),
      .distance_cycles (distance_cycles)
   );

   always #5 clk = ~clk;

   // GPIO block: registers capture on the falling edge and are never reset.
   logic [7:0] gpio_val = '0;
   logic [7:0] gpio_dir = '0;
   logic [7:0] ext_in   = '0;

   always @(negedge clk) begin
      if (io_val_we)  gpio_val[io_pin_num] <= io_in;
      if (io_mode_we) gpio_dir[io_pin_num] <= io_in;
   end

   assign io_out = (gpio_dir & gpio_val) | (~gpio_dir & ext_in);

   typedef struct { logic [2:0] pin; logic in; logic val; logic mode; } wr_t;
   typedef struct { logic to; logic ce; int dmin; int dmax; } res_t;

   wr_t  wr_q[$];
   res_t res_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents a write or a done.
   always @(negedge clk) begin
      wr_t  we;
      res_t re;
      if (io_val_we || io_mode_we) begin
         wr_count++;
         if (wr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: pin %0d in %0d val_we %0b mode_we %0b, expected no write",
                     io_pin_num, io_in, io_val_we, io_mode_we);
         end else begin
            we = wr_q.pop_front();
            chk("write{pin,in,val_we,mode_we}", {io_pin_num, io_in, io_val_we, io_mode_we},
                {we.pin, we.in, we.val, we.mode});
         end
      end
      if (done) begin
         done_count++;
         if (res_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no done");
         end else begin
            re = res_q.pop_front();
            chk("timeout", timeout, re.to);
            chk("cfg_err", cfg_err, re.ce);
            checks++;
            if (int'(distance_cycles) < re.dmin || int'(distance_cycles) > re.dmax) begin
               errors++;
               $display("FAIL distance: got %0d expected %0d..%0d", distance_cycles, re.dmin, re.dmax);
            end
         end
      end
   end

   task automatic push_writes(input logic [2:0] t, input logic [2:0] e, input bit with_lo);
      wr_q.push_back('{pin: t, in: 1'b0, val: 1'b1, mode: 1'b0});
      wr_q.push_back('{pin: t, in: 1'b1, val: 1'b0, mode: 1'b1});
      wr_q.push_back('{pin: e, in: 1'b0, val: 1'b0, mode: 1'b1});
      wr_q.push_back('{pin: t, in: 1'b1, val: 1'b1, mode: 1'b0});
      if (with_lo) wr_q.push_back('{pin: t, in: 1'b0, val: 1'b1, mode: 1'b0});
   endtask

   task automatic push_res(input logic to, input logic ce, input int dmin, input int dmax);
      res_q.push_back('{to: to, ce: ce, dmin: dmin, dmax: dmax});
   endtask

   task automatic pulse_start(input logic [2:0] t, input logic [2:0] e);
      @(negedge clk); #1;
      trig_pin = t;
      echo_pin = e;
      start    = 1'b1;
      @(negedge clk); #1;
      start    = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int n);
      bit seen;
      seen = 1'b0;
      n = 0;
      while (!seen && n < limit) begin
         @(negedge clk); #1;
         n++;
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL wait_done: got no done expected one within %0d cycles", limit);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      chk("wait_idle_busy", busy, 0);
   endtask

   // Returns in the TRIG_LO cycle with the sampled trigger high width.
   task automatic wait_trig(input logic [2:0] t, output int hi);
      int n;
      n  = 0;
      hi = 0;
      while (gpio_val[t] && n < 40) begin @(negedge clk); #1; n++; end
      while (!gpio_val[t] && n < 40) begin @(negedge clk); #1; n++; end
      while (gpio_val[t] && n < 80) begin
         hi++;
         @(negedge clk); #1;
         n++;
      end
   endtask

   initial begin
      int hi;
      int n;
      int m;
      int dc0;

      // Reset state
      #1 reset = 1'b0;
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_val_we", io_val_we, 0);
      chk("rst_mode_we", io_mode_we, 0);
      chk("rst_pin_num", io_pin_num, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_distance", distance_cycles, 0);
      repeat (3) @(negedge clk);
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);

      // Normal ping: echo 20 clocks wide, rising 10 clocks after trigger falls
      push_writes(3'd2, 3'd5, 1'b1);
      push_res(1'b0, 1'b0, 19, 21);
      pulse_start(3'd2, 3'd5);
      wait_trig(3'd2, hi);
      chk("normal_trig_high_clks", hi, TRIG + 1);
      repeat (10) @(negedge clk);
      #1 ext_in[5] = 1'b1;
      repeat (20) @(negedge clk);
      #1 ext_in[5] = 1'b0;
      wait_done(20, n);
      wait_idle();

      // Config error: shared pin, done two clocks after start, no writes
      m = wr_count;
      push_res(1'b0, 1'b1, 0, 0);
      pulse_start(3'd3, 3'd3);
      wait_done(10, n);
      chk("cfgerr_done_latency", n + 1, 2);
      wait_idle();
      chk("cfgerr_no_writes", wr_count - m, 0);

      // No echo: timeout 64 clocks after TRIG_LO
      push_writes(3'd2, 3'd5, 1'b1);
      push_res(1'b1, 1'b0, 0, 0);
      pulse_start(3'd2, 3'd5);
      wait_trig(3'd2, hi);
      wait_done(100, n);
      chk("noecho_done_after_trig_lo", n - 1, TO);
      wait_idle();

      // Stuck echo: saturated width
      ext_in[5] = 1'b1;
      push_writes(3'd2, 3'd5, 1'b1);
      push_res(1'b1, 1'b0, TO, TO);
      pulse_start(3'd2, 3'd5);
      wait_trig(3'd2, hi);
      wait_done(100, n);
      wait_idle();
      ext_in[5] = 1'b0;

      // Start during MEASURE and during holdoff are both ignored
      dc0 = done_count;
      push_writes(3'd2, 3'd5, 1'b1);
      push_res(1'b0, 1'b0, 19, 21);
      pulse_start(3'd2, 3'd5);
      wait_trig(3'd2, hi);
      repeat (10) @(negedge clk);
      #1 ext_in[5] = 1'b1;
      repeat (5) @(negedge clk);
      #1 trig_pin = 3'd1; echo_pin = 3'd4; start = 1'b1;
      @(negedge clk);
      #1 start = 1'b0;
      repeat (14) @(negedge clk);
      #1 ext_in[5] = 1'b0;
      wait_done(20, n);
      m = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         start = (i == 2);
         if (!busy) break;
         m++;
      end
      start = 1'b0;
      chk("holdoff_busy_clks", m, HOLD);
      repeat (20) @(negedge clk);
      #1;
      chk("ignored_start_busy", busy, 0);
      chk("exactly_one_done", done_count - dc0, 1);

      // Reset in TRIG_WAIT, then a fresh ping clears the trigger first
      push_writes(3'd2, 3'd5, 1'b0);
      pulse_start(3'd2, 3'd5);
      n = 0;
      while (!gpio_val[2] && n < 40) begin @(negedge clk); #1; n++; end
      repeat (2) @(negedge clk);
      #1 reset = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_val_we", io_val_we, 0);
      chk("abort_pin_num", io_pin_num, 0);
      chk("abort_distance", distance_cycles, 0);
      @(negedge clk);
      #1 reset = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      chk("abort_pending_writes", wr_q.size(), 0);
      chk("abort_trig_left_high", gpio_val[2], 1);
      push_writes(3'd2, 3'd5, 1'b1);
      push_res(1'b1, 1'b0, 0, 0);
      pulse_start(3'd2, 3'd5);
      wait_trig(3'd2, hi);
      chk("restart_trig_high_clks", hi, TRIG + 1);
      wait_done(100, n);
      wait_idle();

      repeat (5) @(negedge clk);
      chk("writes_outstanding", wr_q.size(), 0);
      chk("results_outstanding", res_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
